serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial adder that adds two WIDTH-bit operands LSB-first, one bit per clock, through a single full-adder cell built from two half-adder stages and a carry flip-flop. It sits directly upstream of the half-adder datapath: it sequences operand bits and the carry into the cell and collects the sum bits. It presents a start/busy/done handshake to the surrounding control logic. It trades WIDTH cycles of latency for a one-bit datapath.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2 to 32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when sum and cout become valid.
- sum  output  WIDTH  registered result; held until the next completion.
- cout  output  1  registered carry-out; held until the next completion.

## Operation
- **States:** IDLE, SHIFT, DONE.
- **IDLE:**
  - start=1 loads internal shift registers with a and b, loads the carry flop with cin, clears the bit counter, and moves to SHIFT.
  - start=0 stays in IDLE.
- **SHIFT, each edge:**
  - bit = a_sr[0] ^ b_sr[0] ^ carry.
  - carry <= (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0])).
  - a_sr and b_sr shift right by one.
  - bit enters the accumulator shift register at the MSB; the accumulator shifts right.
  - The counter increments.
  - On the edge that completes bit WIDTH-1, the accumulator is transferred to sum, the final carry to cout, and the state moves to DONE.
- **DONE:** done=1 for exactly one cycle, then the state returns to IDLE unconditionally.
- **start outside IDLE:** ignored in SHIFT and DONE. No queueing and no error flag.
- **Operand isolation:** a, b and cin are don't-care after the accepting edge. Changes during SHIFT do not affect the result.
- **Arithmetic:** {cout, sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- **Counter width:** $clog2(WIDTH). The terminal compare is against WIDTH-1.
- **Reset:** rst_n=0 on any edge, including mid-operation, forces IDLE and clears all registers.
  - busy=0, done=0, sum=0, cout=0.
  - An aborted operation never produces done.

## Timing
- Reset values: busy 0, done 0, sum 0, cout 0, state IDLE.
- Edge 0 samples start=1 in IDLE. busy is high from after edge 0 until after edge WIDTH.
- sum, cout and done update on edge WIDTH. done is high for the cycle between edges WIDTH and WIDTH+1.
- Latency is WIDTH+1 edges from accept to return to IDLE.
- Earliest next accept is edge WIDTH+2, with start high in the cycle after done.
- Maximum throughput: one result per WIDTH+2 cycles.
- sum and cout are stable from the edge that raises done until the edge that raises the next done.

## Structure
- **Shared package serial_add_pkg:**
  - state enum {IDLE, SHIFT, DONE}.
  - WIDTH default constant.
  - Counter-width function.
- **One sub-module, serial_fa_cell:**
  - Combinational full adder built from two half-adder stages plus an OR for carry.
  - Ports: x, y, ci, s, co.
  - Instantiated once. The carry flop stays in serial_adder_ctrl.

## Test plan
All scenarios use WIDTH=8.
- **Basic add:** reset, then a=0x5A, b=0x33, cin=0, 1-cycle start.
  - sum=0x8D, cout=0.
  - done high exactly in the cycle after edge 8; busy high for 8 cycles.
- **Carry ripple:** a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- **Isolation and ignored start:** start the 0x5A+0x33 add, then during SHIFT toggle a/b to 0x00 and hold start=1.
  - Result is still 0x8D with exactly one done pulse.
  - The held start is accepted only in the IDLE cycle after DONE.
- **Reset mid-operation:** start 0x12+0x34, drop rst_n for one edge after 3 shift edges.
  - busy=0, sum=0, cout=0; no done pulse follows.
  - A new start with 0x01+0x01 then yields sum=0x02.
- **Back-to-back and hold:** start 0x10+0x20 (sum=0x30), then assert start in the cycle after done with 0x80+0x80, cin=0.
  - 0x30 remains on sum throughout the second operation.
  - Then sum=0x00, cout=1 with a single done.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the FSM state encoding, default width and counter sizing.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int WIDTH_DEF = 8;

  // Bits needed to count 0 .. w-1; never below one bit.
  function automatic int cnt_width(input int w);
    int r;
    r = $clog2(w);
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational full adder made of two half-adder stages.
// Ports: x, y, ci in; s sum, co carry out.
module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p1;
  logic g1;
  logic g2;

  // first half adder: x + y
  assign p1 = x ^ y;
  assign g1 = x & y;

  // second half adder: partial sum + ci
  assign s  = p1 ^ ci;
  assign g2 = p1 & ci;

  assign co = g1 | g2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: adds a + b + cin LSB-first over WIDTH clocks.
// Ports: clk, rst_n, start, a, b, cin in; busy, done, sum, cout out.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW    = cnt_width(WIDTH);
  localparam int ACC_W = WIDTH - 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e state_q;
  state_e state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] b_d;
  logic             carry_q;
  logic             carry_d;
  // Holds the first WIDTH-1 sum bits; the last
  // bit joins them straight into sum at the end.
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             cout_q;
  logic             cout_d;

  logic fa_s;
  logic fa_co;
  logic last;

  serial_fa_cell u_fa (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last = (cnt_q == LAST);

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // datapath next-state
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_co;
        acc_d   = (acc_q >> 1)
                | (ACC_W'(fa_s) << (ACC_W - 1));
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          sum_d  = {fa_s, acc_q};
          cout_d = fa_co;
        end
      end
      default: ;
    endcase
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8.
// Scenario tasks with inline checks, one summary line.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int errors;
  int checks;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, then wait (bounded) for done.
  // lat = edges after the accept edge; -1 on timeout.
  task automatic run_op(
    input  logic [W-1:0] av,
    input  logic [W-1:0] bv,
    input  logic         cv,
    output int           lat
  );
    a = av;
    b = bv;
    cin = cv;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy, done, sum, cout} !== 11'b0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b sum=%h cout=%b want 0 0 00 0",
               busy, done, sum, cout);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b want 0 0",
               busy, done);
    end
  endtask

  task automatic test_basic();
    int busy_cnt;
    int early_done;
    a = 8'h5A;
    b = 8'h33;
    cin = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = 0;
    early_done = 0;
    for (int i = 1; i <= W; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done !== 1'b0) early_done++;
      tick();
    end
    checks++;
    if (busy_cnt != W || early_done != 0) begin
      errors++;
      $display("FAIL basic_busy: busy_cycles=%0d early_done=%0d want %0d 0",
               busy_cnt, early_done, W);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%b busy=%b want 1 0", done, busy);
    end
    checks++;
    if (sum !== 8'h8D || cout !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum: sum=%h cout=%b want 8d 0", sum, cout);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_carry();
    int lat;
    run_op(8'hFF, 8'h01, 1'b0, lat);
    checks++;
    if (lat != W || sum !== 8'h00 || cout !== 1'b1) begin
      errors++;
      $display("FAIL carry_ff01: lat=%0d sum=%h cout=%b want %0d 00 1",
               lat, sum, cout, W);
    end
    tick();
    run_op(8'hFF, 8'hFF, 1'b1, lat);
    checks++;
    if (lat != W || sum !== 8'hFF || cout !== 1'b1) begin
      errors++;
      $display("FAIL carry_ffff1: lat=%0d sum=%h cout=%b want %0d ff 1",
               lat, sum, cout, W);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int dones;
    a = 8'h12;
    b = 8'h34;
    cin = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b sum=%h cout=%b want 0 0 00 0",
               busy, done, sum, cout);
    end
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL mid_no_done: done_pulses=%0d want 0", dones);
    end
    begin
      int lat;
      run_op(8'h01, 8'h01, 1'b0, lat);
      checks++;
      if (lat != W || sum !== 8'h02 || cout !== 1'b0) begin
        errors++;
        $display("FAIL mid_restart: lat=%0d sum=%h cout=%b want %0d 02 0",
                 lat, sum, cout, W);
      end
    end
    tick();
  endtask

  task automatic test_isolation();
    int dones;
    logic [W-1:0] s8;
    a = 8'h5A;
    b = 8'h33;
    cin = 1'b0;
    start = 1'b1;
    tick();
    a = 8'h00;
    b = 8'h00;
    dones = 0;
    s8 = '0;
    for (int i = 1; i <= W; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    s8 = sum;
    checks++;
    if (s8 !== 8'h8D || done !== 1'b1) begin
      errors++;
      $display("FAIL iso_sum: sum=%h done=%b want 8d 1", s8, done);
    end
    tick();
    if (done === 1'b1) dones++;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL iso_idle: busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL iso_one_done: done_pulses=%0d want 1", dones);
    end
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL iso_reaccept: busy=%b want 1", busy);
    end
    begin
      int lat;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
        tick();
        if (done) begin
          lat = i;
          break;
        end
      end
      checks++;
      if (lat != W || sum !== 8'h00 || cout !== 1'b0) begin
        errors++;
        $display("FAIL iso_second: lat=%0d sum=%h cout=%b want %0d 00 0",
                 lat, sum, cout, W);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    int held_bad;
    int dones;
    run_op(8'h10, 8'h20, 1'b0, lat);
    checks++;
    if (lat != W || sum !== 8'h30 || cout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d sum=%h cout=%b want %0d 30 0",
               lat, sum, cout, W);
    end
    tick();
    a = 8'h80;
    b = 8'h80;
    cin = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b want 1", busy);
    end
    held_bad = 0;
    dones = 0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (sum !== 8'h30) held_bad++;
      tick();
      if (done) begin
        lat = i;
        dones++;
        break;
      end
    end
    checks++;
    if (held_bad != 0) begin
      errors++;
      $display("FAIL b2b_hold: cycles_sum_changed=%0d want 0", held_bad);
    end
    checks++;
    if (lat != W || sum !== 8'h00 || cout !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d sum=%h cout=%b want %0d 00 1",
               lat, sum, cout, W);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 1 || sum !== 8'h00 || cout !== 1'b1) begin
      errors++;
      $display("FAIL b2b_single: done_pulses=%0d sum=%h cout=%b want 1 00 1",
               dones, sum, cout);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_carry();
    test_reset_mid();
    test_isolation();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
